// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter.
// TXDATA at BASE_ADDR (write starts a frame, read returns the last byte sent),
// STATUS at BASE_ADDR+4 (bit0 busy, bit1 sticky overrun, write WD[1]=1 to clear).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_port #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR    = 32'h1001_0000,
  parameter int               CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] Adr,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] RD,
  output logic             tx,
  output logic             busy
);

  localparam logic [WIDTH-1:0] STATUS_ADDR = BASE_ADDR + WIDTH'(4);
  localparam logic [15:0]      BAUD_LAST   = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  lastByte_q, lastByte_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [15:0] baudCnt_q, baudCnt_d;
  logic        tx_q, tx_d;
  logic        overrun_q, overrun_d;

  logic txWrite;
  logic statusWrite;
  logic baudDone;
  logic unusedWdBits;

  assign txWrite      = MemWrite && (Adr == BASE_ADDR);
  assign statusWrite  = MemWrite && (Adr == STATUS_ADDR);
  assign baudDone     = (baudCnt_q == BAUD_LAST);
  assign unusedWdBits = ^WD;

  assign busy = (state_q != IDLE);
  assign tx   = tx_q;

  // Frame sequencing: next state, shift register, bit index and baud counter
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    lastByte_d = lastByte_q;
    bitIdx_d   = bitIdx_q;
    baudCnt_d  = baudCnt_q + 16'd1;
    case (state_q)
      IDLE: begin
        baudCnt_d = '0;
        bitIdx_d  = '0;
        if (txWrite) begin
          shift_d    = WD[7:0];
          lastByte_d = WD[7:0];
          state_d    = START;
        end
      end
      START: begin
        if (baudDone) begin
          baudCnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baudDone) begin
          baudCnt_d = '0;
          if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baudDone) begin
          baudCnt_d = '0;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (baudDone) begin
          baudCnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        baudCnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, derived from where the FSM is heading so tx can be registered
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = ^lastByte_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Sticky overrun: a TXDATA store while a frame is running sets it, a STATUS store clears it, set wins
  always_comb begin
    overrun_d = overrun_q;
    if (statusWrite && WD[1]) begin
      overrun_d = 1'b0;
    end
    if (txWrite && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // Register read mux, purely address-driven
  always_comb begin
    RD = '0;
    if (Adr == BASE_ADDR) begin
      RD[7:0] = lastByte_q;
    end else if (Adr == STATUS_ADDR) begin
      RD[1:0] = {overrun_q, busy};
    end
  end

  // State registers; reset aborts any frame and discards a store in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      lastByte_q <= '0;
      bitIdx_q   <= '0;
      baudCnt_q  <= '0;
      tx_q       <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      lastByte_q <= lastByte_d;
      bitIdx_q   <= bitIdx_d;
      baudCnt_q  <= baudCnt_d;
      tx_q       <= tx_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule
